// File: rtl/framebuffer_fragment_addr_gen.sv
// -----------------------------------------------------------------------------
// framebuffer_fragment_addr_gen
//
// Purpose:
//   Turns a raw pixel stream from the tile/colour buffer into the fragment
//   stream consumed by the framebuffer writer. For every pixel of a rectangular
//   region it emits the pixel-index address, the screen position and a tlast
//   flag on the final pixel. Addresses are generated incrementally: the only
//   multiply happens once in SETUP, so RUN sustains one pixel per cycle,
//   including across row wraps.
//
// Configuration macro:
//   FRAMEBUFFER_FRAGMENT_ADDR_GEN_YFLIP_EN - bottom-up (OpenGL style) row
//   addressing. typos still reports the unflipped y. When undefined the
//   addressing is top-down and conf_y_resolution is unused.
//
// Ports:
//   aclk, resetn           clock, synchronous active-low reset
//   cmd_start              pulse: latch conf_* and start (only while idle)
//   conf_start_x/_y        first column/row, inclusive
//   conf_end_x/_y          last column/row, exclusive
//   conf_x_resolution      line pitch in pixels
//   conf_y_resolution      framebuffer height (y-flip only)
//   busy, done             busy from accepted command; done pulses at the end
//   s_pix_*                input pixel stream (tdata colour, tstrb enable)
//   m_frag_*               output fragment stream (taddr pixel index,
//                          txpos/typos screen position, tlast end of region)
// -----------------------------------------------------------------------------
module framebuffer_fragment_addr_gen #(
    parameter int ADDR_WIDTH  = 32,
    parameter int X_BIT_WIDTH = 11,
    parameter int Y_BIT_WIDTH = 11,
    parameter int PIXEL_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic                   cmd_start,
    input  logic [X_BIT_WIDTH-1:0] conf_start_x,
    input  logic [Y_BIT_WIDTH-1:0] conf_start_y,
    input  logic [X_BIT_WIDTH-1:0] conf_end_x,
    input  logic [Y_BIT_WIDTH-1:0] conf_end_y,
    input  logic [X_BIT_WIDTH-1:0] conf_x_resolution,
    input  logic [Y_BIT_WIDTH-1:0] conf_y_resolution,
    output logic                   busy,
    output logic                   done,
    input  logic                   s_pix_tvalid,
    output logic                   s_pix_tready,
    input  logic [PIXEL_WIDTH-1:0] s_pix_tdata,
    input  logic                   s_pix_tstrb,
    output logic                   m_frag_tvalid,
    input  logic                   m_frag_tready,
    output logic                   m_frag_tlast,
    output logic [PIXEL_WIDTH-1:0] m_frag_tdata,
    output logic                   m_frag_tstrb,
    output logic [ADDR_WIDTH-1:0]  m_frag_taddr,
    output logic [X_BIT_WIDTH-1:0] m_frag_txpos,
    output logic [X_BIT_WIDTH-1:0] m_frag_typos
);

    localparam logic [X_BIT_WIDTH-1:0] X_ONE = X_BIT_WIDTH'(1);
    localparam logic [Y_BIT_WIDTH-1:0] Y_ONE = Y_BIT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  A_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   last_loaded_q;   // tlast pixel already taken

    // Latched region configuration
    logic [X_BIT_WIDTH-1:0] start_x_q;
    logic [Y_BIT_WIDTH-1:0] start_y_q;
    logic [X_BIT_WIDTH-1:0] end_x_q;
    logic [Y_BIT_WIDTH-1:0] end_y_q;
    logic [X_BIT_WIDTH-1:0] xres_q;

    // Walk state
    logic [X_BIT_WIDTH-1:0] x_q;
    logic [Y_BIT_WIDTH-1:0] y_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  row_base_q;

    // Output register
    logic                   tvalid_q;
    logic                   tlast_q;
    logic [PIXEL_WIDTH-1:0] tdata_q;
    logic                   tstrb_q;
    logic [ADDR_WIDTH-1:0]  taddr_q;
    logic [X_BIT_WIDTH-1:0] txpos_q;
    logic [X_BIT_WIDTH-1:0] typos_q;

    logic [ADDR_WIDTH-1:0]  row_base_d;      // first row base, used in SETUP
    logic [ADDR_WIDTH-1:0]  next_row_base_d; // base of the following row
    logic [X_BIT_WIDTH-1:0] end_x_m1;
    logic [Y_BIT_WIDTH-1:0] end_y_m1;
    logic                   x_at_end;
    logic                   y_at_end;
    logic                   region_empty;
    logic                   pix_hs;
    logic                   frag_hs;

`ifdef FRAMEBUFFER_FRAGMENT_ADDR_GEN_YFLIP_EN
    logic [Y_BIT_WIDTH-1:0] yres_q;

    always_ff @(posedge aclk) begin
        if (state_q == ST_IDLE && cmd_start) begin
            yres_q <= conf_y_resolution;
        end
    end
`else
    logic unused_yres;
    assign unused_yres = ^conf_y_resolution;
`endif

    // NOTE: every variable written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        row_base_d      = '0;
        next_row_base_d = '0;
`ifdef FRAMEBUFFER_FRAGMENT_ADDR_GEN_YFLIP_EN
        row_base_d      = (ADDR_WIDTH'(yres_q) - A_ONE - ADDR_WIDTH'(start_y_q))
                          * ADDR_WIDTH'(xres_q) + ADDR_WIDTH'(start_x_q);
        next_row_base_d = row_base_q - ADDR_WIDTH'(xres_q);
`else
        row_base_d      = ADDR_WIDTH'(start_y_q) * ADDR_WIDTH'(xres_q)
                          + ADDR_WIDTH'(start_x_q);
        next_row_base_d = row_base_q + ADDR_WIDTH'(xres_q);
`endif
    end

    assign end_x_m1     = end_x_q - X_ONE;
    assign end_y_m1     = end_y_q - Y_ONE;
    assign x_at_end     = (x_q == end_x_m1);
    assign y_at_end     = (y_q == end_y_m1);
    assign region_empty = (start_x_q >= end_x_q) || (start_y_q >= end_y_q);

    // Single output register: a new pixel can be taken whenever the register
    // is empty or is being drained this cycle, so there is no bubble.
    assign s_pix_tready = (state_q == ST_RUN) && !last_loaded_q
                          && (!tvalid_q || m_frag_tready);
    assign pix_hs       = s_pix_tvalid && s_pix_tready;
    assign frag_hs      = tvalid_q && m_frag_tready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: only control state is reset; configuration, walk counters and the
    // data/address part of the output register are always written before use.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            last_loaded_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_start) begin
                        start_x_q     <= conf_start_x;
                        start_y_q     <= conf_start_y;
                        end_x_q       <= conf_end_x;
                        end_y_q       <= conf_end_y;
                        xres_q        <= conf_x_resolution;
                        busy_q        <= 1'b1;
                        last_loaded_q <= 1'b0;
                        state_q       <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (region_empty) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        row_base_q <= row_base_d;
                        addr_q     <= row_base_d;
                        x_q        <= start_x_q;
                        y_q        <= start_y_q;
                        state_q    <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (pix_hs) begin
                        tvalid_q <= 1'b1;
                        tlast_q  <= x_at_end && y_at_end;
                        tdata_q  <= s_pix_tdata;
                        tstrb_q  <= s_pix_tstrb;
                        taddr_q  <= addr_q;
                        txpos_q  <= x_q;
                        typos_q  <= X_BIT_WIDTH'(y_q);
                        if (x_at_end && y_at_end) begin
                            last_loaded_q <= 1'b1;
                        end
                        if (x_at_end) begin
                            x_q        <= start_x_q;
                            y_q        <= y_q + Y_ONE;
                            row_base_q <= next_row_base_d;
                            addr_q     <= next_row_base_d;
                        end else begin
                            x_q    <= x_q + X_ONE;
                            addr_q <= addr_q + A_ONE;
                        end
                    end else if (frag_hs) begin
                        // pix_hs cannot coincide with the tlast drain: input
                        // is closed once the tlast pixel is loaded.
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        if (tlast_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign m_frag_tvalid = tvalid_q;
    assign m_frag_tlast  = tlast_q;
    assign m_frag_tdata  = tdata_q;
    assign m_frag_tstrb  = tstrb_q;
    assign m_frag_taddr  = taddr_q;
    assign m_frag_txpos  = txpos_q;
    assign m_frag_typos  = typos_q;

endmodule

// File: tb/tb_framebuffer_fragment_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_fragment_addr_gen
//
// Scoreboard bench: each region command pushes its full expected fragment list
// (computed from region geometry with plain arithmetic) and its random pixels.
// A driver feeds pixels, a ready generator shapes backpressure and a monitor
// pops and compares every output handshake, tracks stalls and done pulses.
// -----------------------------------------------------------------------------
module tb_framebuffer_fragment_addr_gen;

    localparam int AW = 32;
    localparam int XW = 11;
    localparam int YW = 11;
    localparam int PW = 16;
    localparam int TIMEOUT = 3000;

`ifdef FRAMEBUFFER_FRAGMENT_ADDR_GEN_YFLIP_EN
    localparam bit YFLIP = 1'b1;
`else
    localparam bit YFLIP = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_start = 1'b0;
    logic [XW-1:0] conf_start_x = '0;
    logic [YW-1:0] conf_start_y = '0;
    logic [XW-1:0] conf_end_x = '0;
    logic [YW-1:0] conf_end_y = '0;
    logic [XW-1:0] conf_x_resolution = '0;
    logic [YW-1:0] conf_y_resolution = '0;
    logic          busy;
    logic          done;
    logic          s_pix_tvalid = 1'b0;
    logic          s_pix_tready;
    logic [PW-1:0] s_pix_tdata = '0;
    logic          s_pix_tstrb = 1'b0;
    logic          m_frag_tvalid;
    logic          m_frag_tready = 1'b0;
    logic          m_frag_tlast;
    logic [PW-1:0] m_frag_tdata;
    logic          m_frag_tstrb;
    logic [AW-1:0] m_frag_taddr;
    logic [XW-1:0] m_frag_txpos;
    logic [XW-1:0] m_frag_typos;

    always #5 aclk = ~aclk;

    framebuffer_fragment_addr_gen #(
        .ADDR_WIDTH (AW),
        .X_BIT_WIDTH(XW),
        .Y_BIT_WIDTH(YW),
        .PIXEL_WIDTH(PW)
    ) dut (
        .aclk             (aclk),
        .resetn           (resetn),
        .cmd_start        (cmd_start),
        .conf_start_x     (conf_start_x),
        .conf_start_y     (conf_start_y),
        .conf_end_x       (conf_end_x),
        .conf_end_y       (conf_end_y),
        .conf_x_resolution(conf_x_resolution),
        .conf_y_resolution(conf_y_resolution),
        .busy             (busy),
        .done             (done),
        .s_pix_tvalid     (s_pix_tvalid),
        .s_pix_tready     (s_pix_tready),
        .s_pix_tdata      (s_pix_tdata),
        .s_pix_tstrb      (s_pix_tstrb),
        .m_frag_tvalid    (m_frag_tvalid),
        .m_frag_tready    (m_frag_tready),
        .m_frag_tlast     (m_frag_tlast),
        .m_frag_tdata     (m_frag_tdata),
        .m_frag_tstrb     (m_frag_tstrb),
        .m_frag_taddr     (m_frag_taddr),
        .m_frag_txpos     (m_frag_txpos),
        .m_frag_typos     (m_frag_typos)
    );

    typedef struct packed {
        logic [PW-1:0] data;
        logic          strb;
        logic [AW-1:0] addr;
        logic [XW-1:0] x;
        logic [XW-1:0] y;
        logic          last;
    } frag_t;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          strb;
    } pix_t;

    frag_t       exp_q[$];
    pix_t        pix_q[$];
    int unsigned hs_cycle_q[$];

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          empty_phase = 1'b0;
    bit          gap_en = 1'b0;
    int          tready_mode = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Pixel-index address of screen (x, y) in a framebuffer with pitch xres.
    function automatic logic [AW-1:0] model_addr(input int x, input int y,
                                                 input int xres, input int yres);
        longint row;
        longint a;
        row = YFLIP ? longint'(yres - 1 - y) : longint'(y);
        a   = row * longint'(xres) + longint'(x);
        return AW'(a);
    endfunction

    // ---------------- downstream ready shaping ----------------
    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(posedge aclk);
            #1;
            case (tready_mode)
                0:       m_frag_tready = 1'b1;
                1:       m_frag_tready = ((tcnt % 4) == 0) || ((tcnt % 4) == 3);
                default: m_frag_tready = 1'($urandom_range(0, 1));
            endcase
            tcnt++;
        end
    end

    // ---------------- pixel driver ----------------
    initial begin
        bit hs;
        forever begin
            @(negedge aclk);
            hs = s_pix_tvalid && s_pix_tready;
            @(posedge aclk);
            #1;
            if (!resetn) begin
                pix_q.delete();
                s_pix_tvalid = 1'b0;
            end else begin
                if (hs) begin
                    if (pix_q.size() > 0) void'(pix_q.pop_front());
                    s_pix_tvalid = 1'b0;
                end
                if (!s_pix_tvalid && pix_q.size() > 0) begin
                    if (!gap_en || $urandom_range(0, 3) != 0) begin
                        s_pix_tvalid = 1'b1;
                        s_pix_tdata  = pix_q[0].data;
                        s_pix_tstrb  = pix_q[0].strb;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    frag_t cur;
    always_comb cur = {m_frag_tdata, m_frag_tstrb, m_frag_taddr, m_frag_txpos,
                       m_frag_typos, m_frag_tlast};

    initial begin
        frag_t held;
        frag_t e;
        bit    stall_prev;
        bit    done_due;
        stall_prev = 1'b0;
        done_due   = 1'b0;
        forever begin
            @(negedge aclk);
            if (!resetn) begin
                exp_q.delete();
                stall_prev = 1'b0;
                done_due   = 1'b0;
            end else begin
                if (done_due) begin
                    check("done_after_tlast", 128'(done), 128'(1));
                    done_due = 1'b0;
                end else if (done && !empty_phase) begin
                    check("unexpected_done", 128'(done), 128'(0));
                end
                if (stall_prev) begin
                    check("stall_tvalid_held", 128'(m_frag_tvalid), 128'(1));
                    check("stall_frag_held", 128'(cur), 128'(held));
                end
                if (m_frag_tvalid && !m_frag_tready) begin
                    check("stall_pix_tready_low", 128'(s_pix_tready), 128'(0));
                    stall_prev = 1'b1;
                    held       = cur;
                end else begin
                    stall_prev = 1'b0;
                end
                if (m_frag_tvalid && m_frag_tready) begin
                    hs_cycle_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("frag_unexpected", 128'(m_frag_tvalid), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("frag_taddr", 128'(m_frag_taddr), 128'(e.addr));
                        check("frag_txpos", 128'(m_frag_txpos), 128'(e.x));
                        check("frag_typos", 128'(m_frag_typos), 128'(e.y));
                        check("frag_tdata", 128'(m_frag_tdata), 128'(e.data));
                        check("frag_tstrb", 128'(m_frag_tstrb), 128'(e.strb));
                        check("frag_tlast", 128'(m_frag_tlast), 128'(e.last));
                    end
                    if (m_frag_tlast) done_due = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_region(input int sx, input int sy, input int ex, input int ey,
                               input int xres, input int yres);
        frag_t f;
        pix_t  p;
        for (int y = sy; y < ey; y++) begin
            for (int x = sx; x < ex; x++) begin
                p.data = PW'($urandom);
                p.strb = 1'($urandom_range(0, 1));
                f.data = p.data;
                f.strb = p.strb;
                f.addr = model_addr(x, y, xres, yres);
                f.x    = XW'(x);
                f.y    = XW'(y);
                f.last = (x == ex - 1) && (y == ey - 1);
                pix_q.push_back(p);
                exp_q.push_back(f);
            end
        end
    endtask

    task automatic issue_cmd(input int sx, input int sy, input int ex, input int ey,
                             input int xres, input int yres);
        @(posedge aclk);
        #1;
        conf_start_x      = XW'(sx);
        conf_start_y      = YW'(sy);
        conf_end_x        = XW'(ex);
        conf_end_y        = YW'(ey);
        conf_x_resolution = XW'(xres);
        conf_y_resolution = YW'(yres);
        cmd_start         = 1'b1;
        @(posedge aclk);
        #1;
        cmd_start = 1'b0;
    endtask

    task automatic run_region(input int sx, input int sy, input int ex, input int ey,
                              input int xres, input int yres, input int mode,
                              input bit gaps, input bit mid_cmd);
        bit finished;
        if (sx >= ex || sy >= ey) begin
            empty_phase = 1'b1;
            issue_cmd(sx, sy, ex, ey, xres, yres);
            @(negedge aclk);
            check("empty_busy_first", 128'(busy), 128'(1));
            check("empty_no_done_yet", 128'(done), 128'(0));
            @(negedge aclk);
            check("empty_busy_cleared", 128'(busy), 128'(0));
            check("empty_done_pulse", 128'(done), 128'(1));
            check("empty_no_frag", 128'(m_frag_tvalid), 128'(0));
            @(negedge aclk);
            check("empty_done_one_cycle", 128'(done), 128'(0));
            empty_phase = 1'b0;
            return;
        end
        tready_mode = mode;
        gap_en      = gaps;
        push_region(sx, sy, ex, ey, xres, yres);
        issue_cmd(sx, sy, ex, ey, xres, yres);
        @(negedge aclk);
        check("busy_after_cmd", 128'(busy), 128'(1));
        finished = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge aclk);
            if (mid_cmd && i == 4) begin
                conf_start_x      = XW'(sx + 3);
                conf_start_y      = YW'(0);
                conf_end_x        = XW'(ex + 9);
                conf_end_y        = YW'(ey + 2);
                conf_x_resolution = XW'(xres + 100);
                cmd_start         = 1'b1;
            end
            if (mid_cmd && i == 5) cmd_start = 1'b0;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        cmd_start = 1'b0;
        if (!finished) check("region_timeout", 128'(busy), 128'(0));
        check("all_frags_seen", 128'(exp_q.size()), 128'(0));
        @(negedge aclk);
        check("idle_after_done", 128'(busy), 128'(0));
    endtask

    initial begin
        int base;
        bit reached;
        int sx, sy, ex, ey, xr, yr;

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_tvalid", 128'(m_frag_tvalid), 128'(0));
        check("reset_tlast", 128'(m_frag_tlast), 128'(0));
        check("reset_pix_tready", 128'(s_pix_tready), 128'(0));
        @(posedge aclk);
        #3;
        resetn = 1'b1;

        // 4x3 region... 3x2 region, pitch 8, full throughput
        base = hs_cycle_q.size();
        run_region(0, 0, 3, 2, 8, 4, 0, 1'b0, 1'b0);
        if (hs_cycle_q.size() >= base + 6) begin
            check("one_frag_per_cycle",
                  128'(hs_cycle_q[base + 5] - hs_cycle_q[base]), 128'(5));
        end else begin
            check("frag_count_first_region", 128'(hs_cycle_q.size() - base), 128'(6));
        end

        // Single-pixel region
        run_region(5, 4, 6, 5, 640, 480, 0, 1'b0, 1'b0);

        // Backpressure pattern 1,0,0,1
        run_region(0, 0, 3, 2, 8, 4, 1, 1'b0, 1'b0);

        // Empty region
        run_region(4, 0, 4, 2, 8, 4, 0, 1'b0, 1'b0);

        // cmd_start mid-run with a different region is ignored
        run_region(2, 1, 8, 5, 16, 8, 2, 1'b1, 1'b1);

        // Reset in the middle of a region
        tready_mode = 0;
        gap_en      = 1'b0;
        base        = hs_cycle_q.size();
        push_region(0, 0, 3, 2, 8, 4);
        issue_cmd(0, 0, 3, 2, 8, 4);
        reached = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge aclk);
            if (hs_cycle_q.size() >= base + 3) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) check("reset_test_timeout", 128'(hs_cycle_q.size() - base), 128'(3));
        @(posedge aclk);
        #3;
        resetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check("midreset_tvalid", 128'(m_frag_tvalid), 128'(0));
        check("midreset_busy", 128'(busy), 128'(0));
        check("midreset_pix_tready", 128'(s_pix_tready), 128'(0));
        @(posedge aclk);
        #3;
        resetn = 1'b1;
        run_region(1, 2, 4, 4, 10, 6, 0, 1'b0, 1'b0);

`ifdef FRAMEBUFFER_FRAGMENT_ADDR_GEN_YFLIP_EN
        // Bottom-up addressing: expect taddr 24,25,16,17
        run_region(0, 0, 2, 2, 8, 4, 0, 1'b0, 1'b0);
`endif

        // Randomized regions
        for (int n = 0; n < 24; n++) begin
            sx = $urandom_range(0, 40);
            sy = $urandom_range(0, 40);
            ex = sx + $urandom_range(1, 7);
            ey = sy + $urandom_range(1, 4);
            if (n % 8 == 7) ex = sx - $urandom_range(0, 3);
            if (ex < 0) ex = 0;
            xr = ex + $urandom_range(0, 900);
            yr = ey + $urandom_range(0, 400);
            run_region(sx, sy, ex, ey, xr, yr, $urandom_range(0, 2),
                       1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(posedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
